reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised successor to the core's 2R1W integer register file. It adds configurable data width, address width and read-port count, plus an optional hardwired-zero entry and optional same-cycle write-to-read bypass. A sequential clear sequencer zeroes every entry after reset or on request, and signals readiness to the pipeline. It sits in the decode stage of the RISC-V core and feeds the operand muxes.

## Interface

**Parameters**
- `DATA_W`, default 32: entry width in bits.
- `ADDR_W`, default 5: address width; depth is `DEPTH = 2**ADDR_W`.
- `NUM_RD`, default 2: number of independent read ports, 1 to 4.
- `ZERO_REG`, default 1: when 1, entry 0 always reads 0 and writes to it are discarded.
- `BYPASS`, default 1: when 1, a read of the address being written returns `wd` in the same cycle.

**Ports** (clock and reset first)
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `clear_req`, input, 1: one-cycle pulse that requests a full re-zero sweep.
- `we`, input, 1: write enable.
- `wa`, input, `ADDR_W`: write address.
- `wd`, input, `DATA_W`: write data.
- `ra`, input, `NUM_RD*ADDR_W`: packed read addresses; port i uses bits `[i*ADDR_W +: ADDR_W]`.
- `rd`, output, `NUM_RD*DATA_W`: packed read data; port i uses bits `[i*DATA_W +: DATA_W]`.
- `ready`, output, 1: high when the file is in RUN state and accepts writes.

## Operation

**State machine** (states CLEAR and RUN)
- `rst_n` low at a clock edge:
  - Next state is CLEAR and the sweep counter `clr_idx` is set to 0.
  - Array contents are not touched by the reset edge itself.
- CLEAR:
  - Each cycle with `rst_n` high writes 0 to `mem[clr_idx]` and increments `clr_idx`.
  - When `clr_idx == DEPTH-1` is written, the next state is RUN.
  - The sweep takes exactly DEPTH cycles.
- RUN:
  - If `clear_req` is high, the next state is CLEAR and `clr_idx` is set to 0.
  - A write present in that same cycle is still performed.
- `clear_req` during CLEAR is ignored; the sweep does not restart.

**Writes**
- `mem[wa]` is updated at the edge only when all of the following hold: `we`, state RUN, `rst_n` high, and not (`ZERO_REG` and `wa == 0`).
- Writes presented during CLEAR are dropped silently; the producer must gate on `ready`.

**Reads** (combinational, evaluated per port, priority in this order)
1. State is CLEAR: `rd_i = 0`.
2. `ZERO_REG` and `ra_i == 0`: `rd_i = 0`.
3. `BYPASS`, `we`, state RUN, and `ra_i == wa`: `rd_i = wd`.
4. Otherwise: `rd_i = mem[ra_i]`.

**Other rules**
- All address comparisons are full `ADDR_W`-bit compares; there is no aliasing.
- `clr_idx` is `ADDR_W` bits wide. It wraps only on the terminal write, which coincides with the exit from CLEAR.

## Timing

**Reset values**
- Immediately after any `rst_n` low edge: `ready = 0` and `rd = 0` on all ports (CLEAR state).
- `ready` is registered and equals (state == RUN).

**Latency**
- Write to read without bypass: 1 cycle; data is visible combinationally in the cycle after the write edge.
- With bypass: 0 cycles.
- Reset release to `ready`: `rst_n` high for DEPTH edges, then `ready = 1` after the DEPTH-th edge.
- `clear_req` to `ready` low: 1 edge. `ready` returns high DEPTH edges later.

**Boundary conditions**
- Reset asserted mid-sweep: the sweep restarts at index 0 and the full DEPTH cycles are needed again.
- Simultaneous `we` and `clear_req` in RUN: the write lands, then the sweep overwrites it with 0.
- Simultaneous `rst_n` low and `we`: the write is dropped.
- `NUM_RD` ports reading the same address return identical data.

## Structure

**Shared package `reg_file_pkg`**
- State encoding localparams: `RF_CLEAR = 1'b0`, `RF_RUN = 1'b1`.
- Default width constants: `RF_DATA_W = 32`, `RF_ADDR_W = 5`.

**Sub-module `rf_clear_seq`**
- Contains the CLEAR/RUN FSM and the `clr_idx` counter.
- Outputs `clr_we`, `clr_addr` and `ready`.
- The top level muxes the sweep write port against the user write port and generates the read ports with a generate loop.

## Test plan

1. **Reset and sweep:** hold `rst_n` low 3 cycles, then release. Expect `ready = 0` and all `rd = 0` for 32 edges. At the 32nd edge `ready` rises, and reads of x1 through x31 return 0.
2. **Zero register and write latency:** write `wa = 0`, `wd = 32'hDEADBEEF`. Expect `rd` at `ra = 0` to stay 0. Then write `wa = 7`, `wd = 32'h12345678` with `ra0 = 7`. With `BYPASS = 1`, `rd0 = 32'h12345678` in the same cycle. With `BYPASS = 0`, `rd0` shows the old value that cycle and the new value the next cycle.
3. **Read-port independence:** with `NUM_RD = 3`, write x5 = 5, x6 = 6, x7 = 7. Set `ra = {7, 6, 5}`. Expect `rd = {7, 6, 5}`. Then set all three ports to x6 and expect 6 on each.
4. **Runtime clear:** in RUN, pulse `clear_req` together with `we` to x9 = `32'hA5`. Expect `ready = 0` for 32 cycles. Writes issued during the sweep are dropped, and x9 reads 0 once `ready` returns.
5. **Reset mid-sweep:** assert `rst_n` low at sweep cycle 10, release after 1 cycle. Expect `ready` to rise exactly 32 edges after the release, not 22.

Source files
------------

// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the parametrised integer register file.
//   RF_CLEAR / RF_RUN : state encoding of the clear sequencer
//   RF_DATA_W         : default entry width
//   RF_ADDR_W         : default address width (depth = 2**RF_ADDR_W)
//   rf_state_t        : enumerated sequencer state built on the encodings
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam logic RF_CLEAR  = 1'b0;
    localparam logic RF_RUN    = 1'b1;

    localparam int   RF_DATA_W = 32;
    localparam int   RF_ADDR_W = 5;

    typedef enum logic {
        ST_CLEAR = RF_CLEAR,
        ST_RUN   = RF_RUN
    } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// ---------------------------------------------------------------------------
// rf_clear_seq
// CLEAR/RUN sequencer for the register file. After reset, or on a clear
// request while running, it walks clr_addr from 0 to DEPTH-1 (one entry per
// cycle) asking the file to write zero, then enters RUN.
// Ports:
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   clear_req : one-cycle pulse requesting a new sweep (ignored in CLEAR)
//   clr_we    : sweep write strobe (zero is written to clr_addr)
//   clr_addr  : entry currently being cleared
//   ready     : registered, high exactly while in RUN
// ---------------------------------------------------------------------------
module rf_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    rf_state_t         state_reg;
    logic [ADDR_W-1:0] clr_idx_reg;
    logic              ready_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Only the sequencer is reset; the array keeps its contents
            // until the sweep reaches each entry.
            state_reg   <= ST_CLEAR;
            clr_idx_reg <= '0;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    // The counter wraps to 0 on the terminal write, the same
                    // edge that leaves CLEAR, so it is already 0 for the next
                    // sweep.
                    clr_idx_reg <= clr_idx_reg + 1'b1;
                    if (clr_idx_reg == LAST_IDX) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state_reg   <= ST_CLEAR;
                        clr_idx_reg <= '0;
                        ready_reg   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // A reset edge must not write the array, hence the rst_n qualifier.
    assign clr_we   = rst_n && (state_reg == ST_CLEAR);
    assign clr_addr = clr_idx_reg;
    assign ready    = ready_reg;

endmodule

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// Parametrised multi-read, single-write integer register file with optional
// hardwired-zero entry 0, optional write-to-read bypass and a sequential
// clear sweep after reset or on request.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst_n     : synchronous active-low reset
//   clear_req : one-cycle pulse requesting a full re-zero sweep
//   we/wa/wd  : write enable / address / data (accepted only while ready)
//   ra        : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd        : packed read data,      port i at [i*DATA_W +: DATA_W]
//   ready     : high while the file is in RUN and accepts writes
// ---------------------------------------------------------------------------
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic                     ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;
    logic              user_we;
    logic              zero_wa;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .ready     (run)
    );

    assign ready   = run;
    assign zero_wa = (ZERO_REG != 0) && (wa == '0);

    // The user write is only honoured in RUN; a write in the same cycle as
    // a clear request still lands because the state is still RUN.
    assign user_we = we && run && rst_n && !zero_wa;

    // Single physical write port: the sweep and the user never overlap in
    // time (sweep only in CLEAR, user only in RUN), the mux order is just
    // a safe default.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_we) begin
            mem[wa] <= wd;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra_port;
            logic [DATA_W-1:0] rd_port;

            assign ra_port = ra[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd_port = mem[ra_port];
                if (!run) begin
                    rd_port = '0;
                end else if ((ZERO_REG != 0) && (ra_port == '0)) begin
                    rd_port = '0;
                end else if ((BYPASS != 0) && we && (ra_port == wa)) begin
                    // run is already known true here, so this is the
                    // same-cycle forward of an accepted write.
                    rd_port = wd;
                end
            end

            assign rd[gi*DATA_W +: DATA_W] = rd_port;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear_req;
    logic           we;
    logic [AW-1:0]  wa;
    logic [DW-1:0]  wd;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd_a;
    logic           ready_a;
    logic [DW-1:0]  rd_b;
    logic           ready_b;

    always #5 clk = ~clk;

    // Main instance: three read ports, bypass enabled.
    reg_file_param #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .we(we),
        .wa(wa), .wd(wd), .ra(ra), .rd(rd_a), .ready(ready_a)
    );

    // Second instance: one read port, bypass disabled, same stimulus.
    reg_file_param #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(1), .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .we(we),
        .wa(wa), .wd(wd), .ra(ra[AW-1:0]), .rd(rd_b), .ready(ready_b)
    );

    // kind: 0 ready_a, 1..3 rd_a port 0..2, 4 rd_b, 5 ready_b
    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            0:       return {31'd0, ready_a};
            1:       return rd_a[0*DW +: DW];
            2:       return rd_a[1*DW +: DW];
            3:       return rd_a[2*DW +: DW];
            4:       return rd_b;
            default: return {31'd0, ready_b};
        endcase
    endfunction

    // Monitor: the DUT is combinational on reads, so its output for the
    // current cycle is presented at the falling edge; compare everything
    // queued for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e   = sb.pop_front();
            got = actual(e.kind);
            n_cmp++;
            if (got !== e.exp) begin
                n_bad++;
                $display("FAIL %s (kind %0d): got %h expected %h", e.name, e.kind, got, e.exp);
            end else begin
                $display("ok   %s (kind %0d): %h", e.name, e.kind, got);
            end
        end
    end

    task automatic push(input int kind, input logic [31:0] v, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic push_ready(input logic v, input string name);
        push(0, {31'd0, v}, name);
        push(5, {31'd0, v}, name);
    endtask

    task automatic push_rd(input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] pb,
                           input string name);
        push(1, p0, name);
        push(2, p1, name);
        push(3, p2, name);
        push(4, pb, name);
    endtask

    task automatic set_ra(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                          input logic [AW-1:0] r2);
        ra = {r2, r1, r0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clear_req = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;

        // 1. Reset for 3 edges, then DEPTH edges of sweep.
        set_ra(5'd1, 5'd2, 5'd3);
        step();
        push_ready(1'b0, "reset_ready");
        push_rd(0, 0, 0, 0, "reset_rd");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            push_ready(1'b0, "sweep_ready_low");
            if (i % 8 == 0) push_rd(0, 0, 0, 0, "sweep_rd_zero");
            step();
        end
        push_ready(1'b1, "ready_after_32");
        for (int a = 1; a < 32; a++) begin
            set_ra(a[AW-1:0], a[AW-1:0], a[AW-1:0]);
            push_rd(0, 0, 0, 0, "post_sweep_zero");
            step();
        end

        // 2. Zero register and write latency.
        we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; set_ra(5'd0, 5'd0, 5'd0);
        push_rd(0, 0, 0, 0, "x0_write_same_cycle");
        step();
        we = 1'b0;
        push_rd(0, 0, 0, 0, "x0_after_write");
        step();
        we = 1'b1; wa = 5'd7; wd = 32'h12345678; set_ra(5'd7, 5'd7, 5'd7);
        push_rd(32'h12345678, 32'h12345678, 32'h12345678, 32'h0, "x7_bypass");
        step();
        we = 1'b0;
        push_rd(32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, "x7_next_cycle");
        step();

        // 3. Read-port independence.
        we = 1'b1; wa = 5'd5; wd = 32'd5; step();
        wa = 5'd6; wd = 32'd6; step();
        wa = 5'd7; wd = 32'd7; step();
        we = 1'b0;
        set_ra(5'd5, 5'd6, 5'd7);
        push_rd(32'd5, 32'd6, 32'd7, 32'd5, "ports_5_6_7");
        step();
        set_ra(5'd6, 5'd6, 5'd6);
        push_rd(32'd6, 32'd6, 32'd6, 32'd6, "ports_all_x6");
        step();
        // Bypass seen only on the ports addressing the write.
        we = 1'b1; wa = 5'd6; wd = 32'd66; set_ra(5'd6, 5'd5, 5'd6);
        push_rd(32'd66, 32'd5, 32'd66, 32'd6, "mixed_bypass");
        step();
        we = 1'b0;
        push_rd(32'd66, 32'd5, 32'd66, 32'd66, "x6_written");
        step();

        // 4. Runtime clear with a simultaneous write to x9.
        we = 1'b1; wa = 5'd9; wd = 32'hA5; clear_req = 1'b1;
        set_ra(5'd9, 5'd9, 5'd9);
        push_ready(1'b1, "clear_pulse_ready");
        push_rd(32'hA5, 32'hA5, 32'hA5, 32'h0, "clear_pulse_bypass");
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            // Writes during the sweep target x3, already swept after i=3.
            we = 1'b1; wa = 5'd3; wd = 32'hBAD0BAD0;
            clear_req = (i == 20);   // must be ignored in CLEAR
            push_ready(1'b0, "runtime_sweep_ready");
            if (i % 8 == 1) push_rd(0, 0, 0, 0, "runtime_sweep_rd");
            step();
        end
        we = 1'b0; clear_req = 1'b0;
        set_ra(5'd9, 5'd3, 5'd7);
        push_ready(1'b1, "ready_after_clear");
        push_rd(0, 0, 0, 0, "x9_x3_x7_cleared");
        step();
        we = 1'b1; wa = 5'd9; wd = 32'hA5;
        step();
        we = 1'b0;
        push_rd(32'hA5, 32'h0, 32'h0, 32'hA5, "x9_rewritten");
        step();

        // 5. Reset mid-sweep.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        we = 1'b1; wa = 5'd4; wd = 32'h44;
        push_ready(1'b0, "mid_sweep_reset_ready");
        step();
        rst_n = 1'b1; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 21 || i == 22 || i == 31) push_ready(1'b0, "restart_sweep_ready");
            step();
        end
        push_ready(1'b1, "ready_32_after_release");
        set_ra(5'd4, 5'd9, 5'd0);
        push_rd(0, 0, 0, 0, "after_restart_zero");
        step();
        step();

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
